// File: rtl/pipelined_alu.sv
// Two-stage pipelined ALU with valid/ready handshakes on operand input and result output.
// Stage 1 registers the operands and opcode; stage 2 registers the result and flags.
module pipelined_alu #(
  parameter  int WIDTH = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           opcode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 zero,
  output logic                 carry
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_OR  = 3'b011,
    OP_AND = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]   s1_a_q, s1_a_d;
  logic [WIDTH-1:0]   s1_b_q, s1_b_d;
  op_e                s1_op_q, s1_op_d;

  logic               s2_valid_q, s2_valid_d;
  logic [2*WIDTH-1:0] s2_result_q, s2_result_d;
  logic               s2_zero_q, s2_zero_d;
  logic               s2_carry_q, s2_carry_d;

  logic               adv1, adv2;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff, shl, shr;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] alu_result;
  logic               alu_carry;

  // A stage may load when it is empty or its contents are moving on this cycle.
  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;

  assign sum  = {1'b0, s1_a_q} + {1'b0, s1_b_q};
  assign diff = s1_a_q - s1_b_q;
  assign prod = {{WIDTH{1'b0}}, s1_a_q} * {{WIDTH{1'b0}}, s1_b_q};
  assign shl  = s1_a_q << s1_b_q[SHW-1:0];
  assign shr  = s1_a_q >> s1_b_q[SHW-1:0];

  // NOTE: every output of a combinational block gets a default before any branch,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    case (s1_op_q)
      OP_ADD: begin
        alu_result = {{(WIDTH-1){1'b0}}, sum};
        alu_carry  = sum[WIDTH];
      end
      OP_SUB: begin
        alu_result = {{WIDTH{1'b0}}, diff};
        alu_carry  = (s1_a_q < s1_b_q);
      end
      OP_MUL: alu_result = prod;
      OP_OR:  alu_result = {{WIDTH{1'b0}}, s1_a_q | s1_b_q};
      OP_AND: alu_result = {{WIDTH{1'b0}}, s1_a_q & s1_b_q};
      OP_XOR: alu_result = {{WIDTH{1'b0}}, s1_a_q ^ s1_b_q};
      OP_SHL: alu_result = {{WIDTH{1'b0}}, shl};
      OP_SHR: alu_result = {{WIDTH{1'b0}}, shr};
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_op_d     = s1_op_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_zero_d   = s2_zero_q;
    s2_carry_d  = s2_carry_q;
    if (adv1) begin
      s1_valid_d = in_valid;
      s1_a_d     = a;
      s1_b_d     = b;
      s1_op_d    = op_e'(opcode);
    end
    if (adv2) begin
      s2_valid_d  = s1_valid_q;
      s2_result_d = alu_result;
      s2_zero_d   = (alu_result == '0);
      s2_carry_d  = alu_carry;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= OP_ADD;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_zero_q   <= 1'b0;
      s2_carry_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_zero_q   <= s2_zero_d;
      s2_carry_q  <= s2_carry_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = s2_result_q;
  assign zero      = s2_zero_q;
  assign carry     = s2_carry_q;

endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu (WIDTH=4): directed scenarios plus an
// in-order scoreboard fed at operand acceptance and drained at result transfer.
module tb_pipelined_alu;

  localparam int WIDTH = 4;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2:0]         opcode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               zero;
  logic               carry;

  typedef struct packed {
    logic [7:0] res;
    logic       z;
    logic       c;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [7:0] res;
    logic       z;
    logic       c;
  } obs_t;

  exp_t q[$];
  obs_t log_q[$];
  int   n_vec;
  int   n_err;
  int   cyc;

  pipelined_alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [3:0] av, input logic [3:0] bv, input logic [2:0] op);
    int unsigned ai;
    int unsigned bi;
    int unsigned r;
    logic        c;
    exp_t        e;
    ai = av;
    bi = bv;
    r  = 0;
    c  = 1'b0;
    case (op)
      3'd0: begin r = ai + bi; c = (r > 15); end
      3'd1: begin r = (ai - bi) & 15; c = (ai < bi); end
      3'd2: r = ai * bi;
      3'd3: r = ai | bi;
      3'd4: r = ai & bi;
      3'd5: r = ai ^ bi;
      3'd6: r = (ai << (bi % 4)) & 15;
      default: r = ai >> (bi % 4);
    endcase
    e.res = r[7:0];
    e.z   = (r == 0);
    e.c   = c;
    return e;
  endfunction

  // Result consumer: scoreboard compare on each transfer, hold check during stalls.
  task automatic monitor_outputs();
    exp_t       e;
    logic       hold;
    logic [7:0] h_res;
    logic       h_z;
    logic       h_c;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          n_vec++;
          if (out_valid !== 1'b1 || result !== h_res || zero !== h_z || carry !== h_c) begin
            n_err++;
            $display("FAIL stall_hold: out_valid=%b result=%h z=%b c=%b, required 1 %h %b %b",
                     out_valid, result, zero, carry, h_res, h_z, h_c);
          end
        end
        if (out_valid && out_ready) begin
          n_vec++;
          if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_beat: result=%h emitted, required no beat", result);
          end else begin
            e = q.pop_front();
            if ({result, zero, carry} !== {e.res, e.z, e.c}) begin
              n_err++;
              $display("FAIL scoreboard: result=%h z=%b c=%b, required %h %b %b",
                       result, zero, carry, e.res, e.z, e.c);
            end
          end
          log_q.push_back('{cyc, result, zero, carry});
          hold = 1'b0;
        end else if (out_valid) begin
          hold  = 1'b1;
          h_res = result;
          h_z   = zero;
          h_c   = carry;
        end else begin
          hold = 1'b0;
        end
      end
    end
  endtask

  // Entered and left just after a rising edge; pushes the expectation when accepted.
  task automatic send_beat(input logic [3:0] av, input logic [3:0] bv, input logic [2:0] op);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    opcode   = op;
    for (int k = 0; k < 500 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(av, bv, op));
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: in_ready=%b, required 1 within 500 cycles", in_ready);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 1000 && q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    n_vec++;
    if (q.size() !== 0) begin
      n_err++;
      $display("FAIL drain: %0d beats outstanding, required 0", q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    opcode    = '0;
    #3;
    n_vec++;
    if ({out_valid, result, zero, carry, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: ov=%b res=%h z=%b c=%b ir=%b, required 0 00 0 0 1",
               out_valid, result, zero, carry, in_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    send_beat(4'd9, 4'd8, 3'b000);
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_early: out_valid=%b after accept edge, required 0", out_valid);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, result, carry, zero} !== {1'b1, 8'h11, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL add_basic: ov=%b res=%h c=%b z=%b, required 1 11 1 0",
               out_valid, result, carry, zero);
    end
    drain();
  endtask

  task automatic test_opcode_sweep();
    logic [7:0] sweep_exp [8];
    int base;
    sweep_exp = '{8'h10, 8'h0A, 8'h27, 8'h0F, 8'h01, 8'h0E, 8'h08, 8'h01};
    base      = log_q.size();
    out_ready = 1'b1;
    for (int op = 0; op < 8; op++) send_beat(4'hD, 4'h3, op[2:0]);
    in_valid = 1'b0;
    drain();
    n_vec++;
    if (log_q.size() < base + 8) begin
      n_err++;
      $display("FAIL sweep_count: %0d beats, required 8", log_q.size() - base);
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_vec++;
        if (log_q[base+k].res !== sweep_exp[k] || log_q[base+k].c !== (k == 0) ||
            log_q[base+k].cyc !== log_q[base].cyc + k) begin
          n_err++;
          $display("FAIL sweep_op%0d: res=%h c=%b cyc=%0d, required %h %b %0d", k,
                   log_q[base+k].res, log_q[base+k].c, log_q[base+k].cyc,
                   sweep_exp[k], (k == 0), log_q[base].cyc + k);
        end
      end
    end
  endtask

  task automatic test_borrow_zero();
    int base;
    base = log_q.size();
    send_beat(4'd2, 4'd5, 3'b001);
    send_beat(4'd5, 4'd5, 3'b001);
    send_beat(4'hA, 4'h5, 3'b100);
    in_valid = 1'b0;
    drain();
    n_vec++;
    if (log_q.size() < base + 3) begin
      n_err++;
      $display("FAIL borrow_count: %0d beats, required 3", log_q.size() - base);
    end else begin
      n_vec++;
      if ({log_q[base].res, log_q[base].z, log_q[base].c} !== {8'h0D, 1'b0, 1'b1}) begin
        n_err++;
        $display("FAIL sub_borrow: res=%h z=%b c=%b, required 0d 0 1",
                 log_q[base].res, log_q[base].z, log_q[base].c);
      end
      n_vec++;
      if ({log_q[base+1].res, log_q[base+1].z, log_q[base+1].c} !== {8'h00, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL sub_zero: res=%h z=%b c=%b, required 00 1 0",
                 log_q[base+1].res, log_q[base+1].z, log_q[base+1].c);
      end
      n_vec++;
      if ({log_q[base+2].res, log_q[base+2].z} !== {8'h00, 1'b1}) begin
        n_err++;
        $display("FAIL and_zero: res=%h z=%b, required 00 1",
                 log_q[base+2].res, log_q[base+2].z);
      end
    end
  endtask

  task automatic test_backpressure();
    int base;
    base = log_q.size();
    fork
      begin
        for (int i = 0; i < 5; i++) send_beat(i[3:0], 4'd1, 3'b000);
        in_valid = 1'b0;
      end
      begin
        out_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_vec++;
        if ({in_ready, out_valid, result} !== {1'b0, 1'b1, 8'h01}) begin
          n_err++;
          $display("FAIL stall_full: ir=%b ov=%b res=%h, required 0 1 01", in_ready, out_valid, result);
        end
        repeat (2) begin
          @(posedge clk); #1;
          n_vec++;
          if ({in_ready, out_valid, result} !== {1'b0, 1'b1, 8'h01}) begin
            n_err++;
            $display("FAIL stall_hold_res: ir=%b ov=%b res=%h, required 0 1 01", in_ready, out_valid, result);
          end
        end
        out_ready = 1'b1;
      end
    join
    drain();
    n_vec++;
    if (log_q.size() !== base + 5) begin
      n_err++;
      $display("FAIL bp_count: %0d beats, required 5", log_q.size() - base);
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_vec++;
        if (log_q[base+k].res !== 8'(k + 1)) begin
          n_err++;
          $display("FAIL bp_order%0d: res=%h, required %h", k, log_q[base+k].res, 8'(k + 1));
        end
      end
    end
  endtask

  task automatic test_random_stall();
    bit         stream_done;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] rop;
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
          ra  = 4'($urandom_range(0, 15));
          rb  = 4'($urandom_range(0, 15));
          rop = 3'($urandom_range(0, 7));
          send_beat(ra, rb, rop);
        end
        in_valid    = 1'b0;
        stream_done = 1'b1;
      end
      begin
        for (int k = 0; k < 20000 && !(stream_done && q.size() == 0); k++) begin
          out_ready = ($urandom_range(0, 9) < 6);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send_beat(4'd3, 4'd4, 3'b000);
    send_beat(4'd7, 4'd1, 3'b001);
    in_valid = 1'b0;
    n_vec++;
    if ({out_valid, in_ready} !== {1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL mid_full: ov=%b ir=%b, required 1 0", out_valid, in_ready);
    end
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, result, in_ready} !== {1'b0, 8'h00, 1'b1}) begin
      n_err++;
      $display("FAIL mid_async: ov=%b res=%h ir=%b, required 0 00 1", out_valid, result, in_ready);
    end
    q.delete();
    @(posedge clk); #1;
    rst       = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_flush: out_valid=%b after reset, required 0", out_valid);
    end
    send_beat(4'd6, 4'd3, 3'b101);
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, result, zero, carry} !== {1'b1, 8'h05, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL mid_next: ov=%b res=%h z=%b c=%b, required 1 05 0 0",
               out_valid, result, zero, carry);
    end
    drain();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    fork
      monitor_outputs();
    join_none
    test_reset();
    test_opcode_sweep();
    test_borrow_zero();
    test_backpressure();
    test_random_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
